// File: rtl/csa_pipe_addsub.sv
`default_nettype none
// ============================================================================
// Module   : csa_pipe_addsub
// Brief    : Pipelined carry-select adder/subtractor with valid/ready handshakes.
// Revision : 1.0
// ============================================================================
module csa_pipe_addsub #(
   parameter int WIDTH  = 32,
   parameter int BLOCK  = 8,
   parameter int STAGES = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] din1,
   input  logic [WIDTH-1:0] din2,
   input  logic             sub,
   input  logic             carry_in,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] dout,
   output logic             carry_out,
   output logic             overflow,
   output logic             zero
);

   localparam int ST  = (STAGES < 1) ? 1 : STAGES;
   localparam int DIV = ST * BLOCK;
   localparam int SW  = WIDTH / ST;
   localparam int NB  = SW / BLOCK;

   if ((STAGES < 1) || ((WIDTH % DIV) != 0)) begin : g_param_check
      $error("csa_pipe_addsub: WIDTH must be a multiple of STAGES*BLOCK and STAGES >= 1");
   end

   logic             w_adv;
   logic [WIDTH-1:0] w_bx;
   logic             r_ovld;
   logic [WIDTH-1:0] r_dout;
   logic             r_cout;
   logic             r_ovf;
   logic             r_zero;

   // Stall-all: every stage advances together only when the output slot frees up.
   assign w_adv     = !r_ovld || out_ready;
   assign in_ready  = w_adv;
   assign w_bx      = sub ? ~din2 : din2;
   assign out_valid = r_ovld;
   assign dout      = r_dout;
   assign carry_out = r_cout;
   assign overflow  = r_ovf;
   assign zero      = r_zero;

   for (genvar k = 0; k < ST; k++) begin : g_stage
      localparam int RW = WIDTH - k*SW;

      logic [RW-1:0]       w_ain;
      logic [RW-1:0]       w_bin;
      logic [SW-1:0]       w_sum;
      logic [(k+1)*SW-1:0] w_res;
      logic                w_cin;
      logic                w_vin;
      logic                w_cout;
      logic [BLOCK:0]      w_s0;
      logic [BLOCK:0]      w_s1;
      logic [BLOCK:0]      w_sel;
      logic                w_c;

      if (k == 0) begin : g_first
         assign w_ain = din1;
         assign w_bin = w_bx;
         assign w_cin = sub | carry_in;
         assign w_vin = in_valid;
         assign w_res = w_sum;
      end else begin : g_next
         assign w_ain = g_stage[k-1].g_mid.r_a;
         assign w_bin = g_stage[k-1].g_mid.r_b;
         assign w_cin = g_stage[k-1].g_mid.r_c;
         assign w_vin = g_stage[k-1].g_mid.r_vld;
         assign w_res = {w_sum, g_stage[k-1].g_mid.r_res};
      end

      // Group 0 ripples; later groups precompute both carry cases and select.
      always_comb begin
         w_c   = w_cin;
         w_sum = '0;
         w_s0  = '0;
         w_s1  = '0;
         w_sel = '0;
         for (int j = 0; j < NB; j++) begin
            w_s0 = {1'b0, w_ain[j*BLOCK +: BLOCK]} + {1'b0, w_bin[j*BLOCK +: BLOCK]};
            if (j == 0) begin
               w_sel = w_s0 + {{BLOCK{1'b0}}, w_c};
            end else begin
               w_s1  = w_s0 + {{BLOCK{1'b0}}, 1'b1};
               w_sel = w_c ? w_s1 : w_s0;
            end
            w_sum[j*BLOCK +: BLOCK] = w_sel[BLOCK-1:0];
            w_c = w_sel[BLOCK];
         end
         w_cout = w_c;
      end

      if (k < ST-1) begin : g_mid
         logic                r_vld;
         logic [RW-SW-1:0]    r_a;
         logic [RW-SW-1:0]    r_b;
         logic [(k+1)*SW-1:0] r_res;
         logic                r_c;

         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               r_vld <= 1'b0;
               r_a   <= '0;
               r_b   <= '0;
               r_res <= '0;
               r_c   <= 1'b0;
            end else if (w_adv) begin
               r_vld <= w_vin;
               r_a   <= w_ain[RW-1:SW];
               r_b   <= w_bin[RW-1:SW];
               r_res <= w_res;
               r_c   <= w_cout;
            end
         end
      end else begin : g_last
         // Carry into the MSB is recovered as a^b^sum at that bit.
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               r_ovld <= 1'b0;
               r_dout <= '0;
               r_cout <= 1'b0;
               r_ovf  <= 1'b0;
               r_zero <= 1'b0;
            end else if (w_adv) begin
               r_ovld <= w_vin;
               if (w_vin) begin
                  r_dout <= w_res;
                  r_cout <= w_cout;
                  r_ovf  <= w_ain[SW-1] ^ w_bin[SW-1] ^ w_sum[SW-1] ^ w_cout;
                  r_zero <= ~|w_res;
               end
            end
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_csa_pipe_addsub.sv
`default_nettype none
// ============================================================================
// Module   : tb_csa_pipe_addsub
// Brief    : Scoreboard bench for csa_pipe_addsub (32/8/2 and 64/4/4 builds).
// Revision : 1.0
// ============================================================================
module tb_csa_pipe_addsub;

   localparam int W  = 32;
   localparam int W2 = 64;

   logic clk = 1'b0;
   logic rst;

   logic          in_valid, in_ready, sub, carry_in, out_valid, out_ready;
   logic          carry_out, overflow, zero;
   logic [W-1:0]  din1, din2, dout;

   logic          b_in_valid, b_in_ready, b_sub, b_carry_in, b_out_valid, b_out_ready;
   logic          b_carry_out, b_overflow, b_zero;
   logic [W2-1:0] b_din1, b_din2, b_dout;

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;

   logic [66:0] q_exp[$];
   logic [66:0] q2_exp[$];
   int          q_cyc[$];
   int          q2_cyc[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   csa_pipe_addsub #(.WIDTH(W), .BLOCK(8), .STAGES(2)) u_dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .din1(din1), .din2(din2), .sub(sub), .carry_in(carry_in),
      .out_valid(out_valid), .out_ready(out_ready), .dout(dout),
      .carry_out(carry_out), .overflow(overflow), .zero(zero)
   );

   csa_pipe_addsub #(.WIDTH(W2), .BLOCK(4), .STAGES(4)) u_dut64 (
      .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_ready(b_in_ready),
      .din1(b_din1), .din2(b_din2), .sub(b_sub), .carry_in(b_carry_in),
      .out_valid(b_out_valid), .out_ready(b_out_ready), .dout(b_dout),
      .carry_out(b_carry_out), .overflow(b_overflow), .zero(b_zero)
   );

   // Reference: {overflow, carry_out, zero, result zero-extended to 64 bits}
   function automatic logic [66:0] model(input logic [63:0] a, input logic [63:0] b,
                                         input logic s, input logic c, input int w);
      logic [64:0] sum;
      logic [63:0] mask, bb, r;
      logic        c0, co, ov;
      mask = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
      bb   = (s ? ~b : b) & mask;
      c0   = s ? 1'b1 : c;
      sum  = {1'b0, a & mask} + {1'b0, bb} + {64'd0, c0};
      co   = sum[w];
      r    = sum[63:0] & mask;
      ov   = (a[w-1] == bb[w-1]) && (r[w-1] != a[w-1]);
      return {ov, co, (r == 64'd0), r};
   endfunction

   task automatic send(input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic s, input logic c, input logic [66:0] exp);
      int t = 0;
      @(negedge clk);
      in_valid = 1'b1; din1 = a; din2 = b; sub = s; carry_in = c;
      #1;
      while (!in_ready && t < 100) begin @(negedge clk); #1; t++; end
      if (!in_ready) begin
         n_tests++; n_fail++;
         $display("FAIL send_timeout: in_ready=%b required 1", in_ready);
      end else begin
         q_exp.push_back(exp);
         q_cyc.push_back(cyc);
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   task automatic send2(input logic [W2-1:0] a, input logic [W2-1:0] b,
                        input logic s, input logic c, input logic [66:0] exp);
      int t = 0;
      @(negedge clk);
      b_in_valid = 1'b1; b_din1 = a; b_din2 = b; b_sub = s; b_carry_in = c;
      #1;
      while (!b_in_ready && t < 100) begin @(negedge clk); #1; t++; end
      if (!b_in_ready) begin
         n_tests++; n_fail++;
         $display("FAIL send2_timeout: in_ready=%b required 1", b_in_ready);
      end else begin
         q2_exp.push_back(exp);
         q2_cyc.push_back(cyc);
      end
      @(posedge clk); #1;
      b_in_valid = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      in_valid = 1'b0; din1 = '0; din2 = '0; sub = 1'b0; carry_in = 1'b0; out_ready = 1'b0;
      b_in_valid = 1'b0; b_din1 = '0; b_din2 = '0; b_sub = 1'b0; b_carry_in = 1'b0; b_out_ready = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      n_tests++;
      if ({out_valid, dout, carry_out, overflow, zero} !== '0) begin
         n_fail++;
         $display("FAIL reset_held: got %h required 0", {out_valid, dout, carry_out, overflow, zero});
      end
      @(negedge clk); rst = 1'b0; #1;
      n_tests++;
      if ({in_ready, out_valid, dout, carry_out, overflow, zero} !== {1'b1, 36'h0}) begin
         n_fail++;
         $display("FAIL reset_release: got %h required %h",
                  {in_ready, out_valid, dout, carry_out, overflow, zero}, {1'b1, 36'h0});
      end
      n_tests++;
      if ({b_in_ready, b_out_valid, b_dout, b_carry_out, b_overflow, b_zero} !== {1'b1, 68'h0}) begin
         n_fail++;
         $display("FAIL reset_release64: got %h required %h",
                  {b_in_ready, b_out_valid, b_dout, b_carry_out, b_overflow, b_zero}, {1'b1, 68'h0});
      end
   endtask

   task automatic test_directed();
      logic [W-1:0] ta[10], tbv[10], td[10];
      logic [2:0]   tf[10];
      logic         ts[10], tcn[10];
      logic [66:0]  exp, act;
      int           acc, t;
      bit           got;
      ta  = '{32'h0000_00FF, 32'h0000_FFFF, 32'hFFFF_FFFF, 32'h8000_0000, 32'd5,
              32'h7FFF_FFFF, 32'h0000_000A, 32'h0, 32'h00FF_FF00, 32'hFFFF_FFFF};
      tbv = '{32'd1, 32'd1, 32'd1, 32'd1, 32'd7, 32'd0, 32'h0000_000A, 32'd0, 32'h0000_0100, 32'd0};
      ts  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
      tcn = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
      td  = '{32'h0000_0100, 32'h0001_0000, 32'h0, 32'h7FFF_FFFF, 32'hFFFF_FFFE,
              32'h8000_0000, 32'h0, 32'h0, 32'h0100_0000, 32'h0};
      // {overflow, carry_out, zero}
      tf  = '{3'b000, 3'b000, 3'b011, 3'b110, 3'b000, 3'b100, 3'b011, 3'b001, 3'b000, 3'b011};
      out_ready = 1'b1;
      for (int i = 0; i < 10; i++) begin
         send(ta[i], tbv[i], ts[i], tcn[i], {tf[i], 32'h0, td[i]});
         got = 1'b0; t = 0;
         while (!got && t < 20) begin
            @(negedge clk); #1; t++;
            if (out_valid && out_ready) begin
               got = 1'b1;
               if (q_exp.size() == 0) begin
                  n_tests++; n_fail++;
                  $display("FAIL directed_spurious[%0d]: got output required none", i);
               end else begin
                  exp = q_exp.pop_front(); acc = q_cyc.pop_front();
                  act = {overflow, carry_out, zero, 32'h0, dout};
                  n_tests++;
                  if (act !== exp) begin
                     n_fail++;
                     $display("FAIL directed[%0d]: got %h required %h", i, act, exp);
                  end
                  n_tests++;
                  if (cyc - acc != 2) begin
                     n_fail++;
                     $display("FAIL directed_latency[%0d]: got %0d required 2", i, cyc - acc);
                  end
               end
            end
         end
         if (!got) begin
            n_tests++; n_fail++;
            $display("FAIL directed_timeout[%0d]: got no output required 1", i);
         end
      end
   endtask

   task automatic test_back_to_back();
      out_ready = 1'b1;
      fork
         begin
            logic [W-1:0] a, b;
            logic s, c;
            for (int i = 0; i < 8; i++) begin
               a = $urandom; b = $urandom; s = 1'($urandom_range(0, 1)); c = 1'($urandom_range(0, 1));
               send(a, b, s, c, model(64'(a), 64'(b), s, c, W));
            end
         end
         begin
            logic [66:0] exp, act;
            int got = 0, t = 0, acc, prev = 0;
            while (got < 8 && t < 60) begin
               @(negedge clk); #1; t++;
               if (out_valid && out_ready) begin
                  if (q_exp.size() == 0) begin
                     n_tests++; n_fail++;
                     $display("FAIL b2b_spurious: got output required none");
                  end else begin
                     exp = q_exp.pop_front(); acc = q_cyc.pop_front();
                     act = {overflow, carry_out, zero, 32'h0, dout};
                     n_tests++;
                     if (act !== exp) begin
                        n_fail++;
                        $display("FAIL b2b[%0d]: got %h required %h", got, act, exp);
                     end
                     n_tests++;
                     if (cyc - acc != 2) begin
                        n_fail++;
                        $display("FAIL b2b_latency[%0d]: got %0d required 2", got, cyc - acc);
                     end
                     if (got > 0) begin
                        n_tests++;
                        if (cyc != prev + 1) begin
                           n_fail++;
                           $display("FAIL b2b_gap[%0d]: got cycle %0d required %0d", got, cyc, prev + 1);
                        end
                     end
                  end
                  prev = cyc; got++;
               end
            end
            if (got < 8) begin
               n_tests++; n_fail++;
               $display("FAIL b2b_timeout: got %0d results required 8", got);
            end
         end
      join
   endtask

   task automatic test_backpressure();
      out_ready = 1'b1;
      fork
         begin
            logic [W-1:0] a, b;
            logic s;
            for (int i = 0; i < 12; i++) begin
               a = $urandom; b = $urandom; s = 1'($urandom_range(0, 1));
               send(a, b, s, 1'b0, model(64'(a), 64'(b), s, 1'b0, W));
            end
         end
         begin
            logic [66:0] exp, act;
            int got = 0, t = 0;
            while (got < 12 && t < 100) begin
               @(negedge clk); #1; t++;
               if (out_valid && out_ready) begin
                  if (q_exp.size() == 0) begin
                     n_tests++; n_fail++;
                     $display("FAIL bp_duplicate: got extra output required none");
                  end else begin
                     exp = q_exp.pop_front(); void'(q_cyc.pop_front());
                     act = {overflow, carry_out, zero, 32'h0, dout};
                     n_tests++;
                     if (act !== exp) begin
                        n_fail++;
                        $display("FAIL bp[%0d]: got %h required %h", got, act, exp);
                     end
                  end
                  got++;
               end
            end
            if (got < 12) begin
               n_tests++; n_fail++;
               $display("FAIL bp_timeout: got %0d results required 12", got);
            end
         end
         begin
            logic [66:0] held;
            repeat (4) @(negedge clk);
            out_ready = 1'b0; #1;
            held = {overflow, carry_out, zero, 32'h0, dout};
            repeat (5) begin
               @(negedge clk); #1;
               n_tests++;
               if ({out_valid, in_ready} !== 2'b10) begin
                  n_fail++;
                  $display("FAIL bp_stall_ready: got valid/ready %b required 10", {out_valid, in_ready});
               end
               n_tests++;
               if ({overflow, carry_out, zero, 32'h0, dout} !== held) begin
                  n_fail++;
                  $display("FAIL bp_stall_hold: got %h required %h",
                           {overflow, carry_out, zero, 32'h0, dout}, held);
               end
            end
            @(negedge clk);
            out_ready = 1'b1;
         end
      join
      repeat (3) @(negedge clk);
      #1;
      n_tests++;
      if (out_valid !== 1'b0 || q_exp.size() != 0) begin
         n_fail++;
         $display("FAIL bp_drain: got valid=%b pending=%0d required 0/0", out_valid, q_exp.size());
      end
   endtask

   task automatic test_reset_flight();
      bit stale = 1'b0;
      out_ready = 1'b1;
      send(32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0, model(64'h1234_5678, 64'h1111_1111, 1'b0, 1'b0, W));
      send(32'hDEAD_BEEF, 32'h0000_0001, 1'b1, 1'b0, model(64'hDEAD_BEEF, 64'h1, 1'b1, 1'b0, W));
      #1;
      rst = 1'b1;
      #1;
      n_tests++;
      if ({out_valid, dout, carry_out, overflow, zero} !== '0) begin
         n_fail++;
         $display("FAIL flight_reset: got %h required 0", {out_valid, dout, carry_out, overflow, zero});
      end
      q_exp.delete(); q_cyc.delete();
      @(posedge clk); #1;
      n_tests++;
      if (out_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL flight_next: got out_valid=%b required 0", out_valid);
      end
      repeat (2) @(negedge clk);
      rst = 1'b0;
      repeat (6) begin
         @(negedge clk); #1;
         if (out_valid !== 1'b0) stale = 1'b1;
      end
      n_tests++;
      if (stale || in_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL flight_stale: got stale=%b in_ready=%b required 0/1", stale, in_ready);
      end
   endtask

   task automatic test_wide();
      b_out_ready = 1'b1;
      fork
         begin
            logic [W2-1:0] a, b;
            logic s, c;
            send2('1, 64'd1, 1'b0, 1'b0, {3'b011, 64'h0});
            send2(64'h8000_0000_0000_0000, 64'd1, 1'b1, 1'b0, {3'b110, 64'h7FFF_FFFF_FFFF_FFFF});
            send2(64'h0000_0000_FFFF_FFFF, 64'd1, 1'b0, 1'b0, {3'b000, 64'h0000_0001_0000_0000});
            send2(64'd5, 64'd7, 1'b1, 1'b0, {3'b000, 64'hFFFF_FFFF_FFFF_FFFE});
            for (int i = 0; i < 8; i++) begin
               a = {$urandom, $urandom}; b = {$urandom, $urandom};
               s = 1'($urandom_range(0, 1)); c = 1'($urandom_range(0, 1));
               send2(a, b, s, c, model(a, b, s, c, W2));
            end
         end
         begin
            logic [66:0] exp, act;
            int got = 0, t = 0, acc, prev = 0;
            while (got < 12 && t < 100) begin
               @(negedge clk); #1; t++;
               if (b_out_valid && b_out_ready) begin
                  if (q2_exp.size() == 0) begin
                     n_tests++; n_fail++;
                     $display("FAIL wide_spurious: got output required none");
                  end else begin
                     exp = q2_exp.pop_front(); acc = q2_cyc.pop_front();
                     act = {b_overflow, b_carry_out, b_zero, b_dout};
                     n_tests++;
                     if (act !== exp) begin
                        n_fail++;
                        $display("FAIL wide[%0d]: got %h required %h", got, act, exp);
                     end
                     n_tests++;
                     if (cyc - acc != 4) begin
                        n_fail++;
                        $display("FAIL wide_latency[%0d]: got %0d required 4", got, cyc - acc);
                     end
                     if (got > 0) begin
                        n_tests++;
                        if (cyc != prev + 1) begin
                           n_fail++;
                           $display("FAIL wide_gap[%0d]: got cycle %0d required %0d", got, cyc, prev + 1);
                        end
                     end
                  end
                  prev = cyc; got++;
               end
            end
            if (got < 12) begin
               n_tests++; n_fail++;
               $display("FAIL wide_timeout: got %0d results required 12", got);
            end
         end
      join
   endtask

   initial begin
      test_reset();
      test_directed();
      test_back_to_back();
      test_backpressure();
      test_reset_flight();
      test_wide();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation still running at %0t", $time);
      $fatal(1, "watchdog expired");
   end

endmodule
`default_nettype wire
